pipe_scheduler: RTL and testbench
=================================

// Module: pipe_scheduler
// PURPOSE
//  Game-level sequencer for the scrolling pipe obstacles. Owns NPIPE pipe slots and runs the IDLE/RUN/HALT game FSM.
//  On each physics strobe it scrolls, retires and spawns pipes and assigns their gap centres.
//  Counts score as pipes pass the bird. Sits between the input/collision logic and the pipe draw logic.
// PARAMETERS
//  NPIPE    3     number of pipe slots (1..8)
//  SPEED    7     pixels moved per physics strobe
//  SPAWN_X  680   x of a newly spawned pipe centre (off-screen right)
//  SPACING  280   scrolled distance between consecutive spawns
//  BIRD_X   160   bird centre x; a pipe centre crossing it scores
//  GAP_MIN  100   lowest gap centre (LFSR mode); GAP_MIN+255 must fit the display
// PORTS
//  i_clk          in   1         base clock
//  i_rst          in   1         synchronous, active-high reset
//  i_physics_stb  in   1         1-cycle physics tick
//  i_start        in   1         level: start a game / leave HALT
//  i_collide      in   1         level: bird hit pipe or ground
//  o_state        out  2         0=IDLE 1=RUN 2=HALT
//  o_pipe_valid   out  NPIPE     slot i holds a live pipe
//  o_pipe_x       out  12*NPIPE  slot i centre x at bits [12i+11:12i]
//  o_pipe_y       out  12*NPIPE  slot i gap centre y, same packing
//  o_score        out  16        pipes passed, saturates at 16'hFFFF
//  o_score_pulse  out  1         1-cycle pulse on the strobe that increments the score
// BEHAVIOUR
//  Reset
//   i_rst has priority over all other inputs.
//   Reset values: o_state=IDLE; valid, x, y, score and pulse all 0; dist=0; gap index/LFSR to seed.
//  IDLE
//   Slots are held invalid. i_start -> RUN on the next clock.
//   On that transition: score=0, dist=SPACING, so the first spawn occurs on the first strobe in RUN.
//  RUN, on i_physics_stb only (registers hold otherwise)
//   Per valid slot with old x<=SPEED: slot invalidated (retire); x/y are don't-care.
//   Per valid slot with old x>SPEED: x<=x-SPEED.
//   Score: count slots with old x>=BIRD_X and new x<BIRD_X. Add the count, saturating; pulse if the count is >0.
//   Spawn: when dist+SPEED>=SPACING and a slot was free before this strobe:
//    - target is the lowest-index free slot; it gets valid=1, x=SPAWN_X, y=next gap value;
//    - gap generator advances; dist<=0.
//   A slot retired on a strobe is not reusable on that same strobe.
//   No free slot: dist saturates at SPACING and the spawn retries on every later strobe.
//   Otherwise dist<=dist+SPEED.
//  RUN exit
//   i_collide -> HALT on the next clock, even if a strobe occurs in the same cycle; that strobe is ignored.
//   i_collide has priority over i_start.
//  HALT
//   Slots and score are frozen and stay visible.
//   i_start -> IDLE, which clears the slots; the score is retained until the next IDLE->RUN.
//  Timing
//   Outputs are registered, with a 1-cycle latency from strobe to updated outputs.
// CONFIGURATION
//  Macro PIPE_LFSR_EN.
//  Undefined: gap y comes from a 16-entry constant table in cyclic order, starting at index 0 after reset/IDLE:
//   220,130,310,290,160,370,120,390,275,225,100,130,190,340,280,90.
//  Defined:
//   16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1, stepped every i_clk cycle.
//   y = GAP_MIN + lfsr[7:0].
// STRUCTURE
//  pipe_pkg: state encodings (ST_IDLE/ST_RUN/ST_HALT), gap table, LFSR seed/taps, coordinate width (12).
//  Sub-module gap_gen: table or LFSR behind PIPE_LFSR_EN, with i_advance and o_gap[11:0].
//  Scheduler instantiates one gap_gen; slot logic uses a generate loop.
// TESTING
//  Reset, then i_start, then 1 strobe -> state=RUN, slot0 valid, x=680, y=220 (table mode).
//  40 strobes after first spawn -> slot1 spawns x=680, y=130; slot0 x=400.
//  75th strobe after a spawn (x 162->155) -> score+1 with one o_score_pulse; no pulse on adjacent strobes.
//  Slot at x=8: next strobe -> x=1; following strobe -> valid=0; reused only on a later strobe.
//  NPIPE=1 -> second spawn waits, dist saturates; spawn occurs on the strobe after slot0 retires.
//  i_collide with a simultaneous strobe -> HALT, positions unchanged.
//  Then i_start -> IDLE, all slots invalid.
//  i_rst mid-RUN -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe scheduler: FSM encodings, coordinate width,
// gap constant table and the LFSR seed/taps.
package pipe_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Gap centres handed out in cyclic order when the LFSR is not built in
    function automatic logic [COORD_W-1:0] gap_table(input logic [3:0] idx);
        logic [COORD_W-1:0] val;
        case (idx)
            4'd0:    val = 12'd220;
            4'd1:    val = 12'd130;
            4'd2:    val = 12'd310;
            4'd3:    val = 12'd290;
            4'd4:    val = 12'd160;
            4'd5:    val = 12'd370;
            4'd6:    val = 12'd120;
            4'd7:    val = 12'd390;
            4'd8:    val = 12'd275;
            4'd9:    val = 12'd225;
            4'd10:   val = 12'd100;
            4'd11:   val = 12'd130;
            4'd12:   val = 12'd190;
            4'd13:   val = 12'd340;
            4'd14:   val = 12'd280;
            default: val = 12'd90;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Control/status bundle between the game logic and the pipe scheduler.
// master = game/input side, slave = scheduler.
interface pipe_scheduler_if
    import pipe_pkg::*;
#(
    parameter int NPIPE = 3
);
    logic                       i_physics_stb;
    logic                       i_start;
    logic                       i_collide;
    logic [1:0]                 o_state;
    logic [NPIPE-1:0]           o_pipe_valid;
    logic [COORD_W*NPIPE-1:0]   o_pipe_x;
    logic [COORD_W*NPIPE-1:0]   o_pipe_y;
    logic [15:0]                o_score;
    logic                       o_score_pulse;

    modport master (
        output i_physics_stb, i_start, i_collide,
        input  o_state, o_pipe_valid, o_pipe_x, o_pipe_y, o_score, o_score_pulse
    );

    modport slave (
        input  i_physics_stb, i_start, i_collide,
        output o_state, o_pipe_valid, o_pipe_x, o_pipe_y, o_score, o_score_pulse
    );
endinterface

// File: rtl/gap_gen.sv
// Gap-centre generator. Default build walks the constant table, restarting at
// entry 0 whenever i_clear is high. With PIPE_LFSR_EN defined, a free-running
// 16-bit Galois LFSR supplies GAP_MIN + lfsr[7:0] instead.
module gap_gen
    import pipe_pkg::*;
#(
    parameter int GAP_MIN = 100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [COORD_W-1:0] o_gap
);
`ifdef PIPE_LFSR_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        unused_ctrl;

    // The LFSR runs every cycle, so clear/advance play no part here
    assign unused_ctrl = i_clear | i_advance;

    // One Galois step per clock
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    // LFSR register, seeded on reset only
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_gap = COORD_W'(GAP_MIN) + {4'd0, lfsr_q[7:0]};
`else
    logic [3:0] idx_q;
    logic [3:0] idx_d;

    // Table index: restart on clear, step on each spawn
    always_comb begin
        idx_d = idx_q;
        if (i_clear) begin
            idx_d = 4'd0;
        end else if (i_advance) begin
            idx_d = idx_q + 4'd1;
        end
    end

    // Index register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q <= 4'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign o_gap = gap_table(idx_q);
`endif
endmodule

// File: rtl/pipe_scheduler.sv
// Game sequencer for the scrolling pipes: IDLE/RUN/HALT FSM, NPIPE pipe slots
// that scroll/retire/spawn on each physics strobe, and the score counter.
// Gap source selected by PIPE_LFSR_EN inside gap_gen (table when undefined).
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int NPIPE   = 3,
    parameter int SPEED   = 7,
    parameter int SPAWN_X = 680,
    parameter int SPACING = 280,
    parameter int BIRD_X  = 160,
    parameter int GAP_MIN = 100
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pipe_scheduler_if.slave   bus
);
    localparam logic [COORD_W-1:0] SPEED_C   = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] SPAWN_C   = COORD_W'(SPAWN_X);
    localparam logic [COORD_W-1:0] BIRD_C    = COORD_W'(BIRD_X);
    localparam logic [15:0]        D_SPEED   = 16'(SPEED);
    localparam logic [15:0]        D_SPACING = 16'(SPACING);

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        dist_q;
    logic [15:0]        dist_d;
    logic [15:0]        score_q;
    logic [15:0]        score_d;
    logic               pulse_q;
    logic               pulse_d;
    logic [NPIPE-1:0]   valid_vec;
    logic [NPIPE-1:0]   free_vec;
    logic [NPIPE-1:0]   pick_vec;
    logic [NPIPE-1:0]   cross_vec;
    logic [COORD_W-1:0] gap;
    logic               run_stb;
    logic               go_run;
    logic               clear_slots;
    logic               spawn_due;
    logic               spawn;
    logic [16:0]        score_sum;

    // A collision in the same cycle as a strobe wins: that strobe is dropped
    assign run_stb     = (state_q == ST_RUN) && bus.i_physics_stb && !bus.i_collide;
    assign go_run      = (state_q == ST_IDLE) && bus.i_start;
    assign clear_slots = (state_q == ST_IDLE) || ((state_q == ST_HALT) && bus.i_start);
    assign free_vec    = ~valid_vec;
    // Isolate the lowest set bit: lowest-index slot that was free before the strobe
    assign pick_vec    = free_vec & (~free_vec + NPIPE'(1));
    assign spawn_due   = (dist_q + D_SPEED) >= D_SPACING;
    assign spawn       = run_stb && spawn_due && (|free_vec);

    gap_gen #(
        .GAP_MIN   (GAP_MIN)
    ) u_gap_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (state_q == ST_IDLE),
        .i_advance (spawn),
        .o_gap     (gap)
    );

    // Game FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_start)   state_d = ST_RUN;
            ST_RUN:  if (bus.i_collide) state_d = ST_HALT;
            ST_HALT: if (bus.i_start)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Spawn distance and saturating score; distance pins at SPACING while all slots are busy
    always_comb begin
        dist_d    = dist_q;
        score_d   = score_q;
        pulse_d   = 1'b0;
        score_sum = {1'b0, score_q} + 17'($countones(cross_vec));
        if (go_run) begin
            dist_d  = D_SPACING;
            score_d = 16'd0;
        end else if (run_stb) begin
            if (spawn_due) begin
                dist_d = (|free_vec) ? 16'd0 : D_SPACING;
            end else begin
                dist_d = dist_q + D_SPEED;
            end
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            pulse_d = |cross_vec;
        end
    end

    // Distance/score/pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dist_q  <= 16'd0;
            score_q <= 16'd0;
            pulse_q <= 1'b0;
        end else begin
            dist_q  <= dist_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
        end
    end

    for (genvar gi = 0; gi < NPIPE; gi++) begin : g_slot
        logic               valid_q;
        logic               valid_d;
        logic [COORD_W-1:0] x_q;
        logic [COORD_W-1:0] x_d;
        logic [COORD_W-1:0] y_q;
        logic [COORD_W-1:0] y_d;
        logic [COORD_W-1:0] x_moved;

        assign x_moved        = x_q - SPEED_C;
        assign cross_vec[gi]  = valid_q && (x_q > SPEED_C) && (x_q >= BIRD_C) && (x_moved < BIRD_C);
        assign valid_vec[gi]  = valid_q;
        assign bus.o_pipe_x[COORD_W*gi +: COORD_W] = x_q;
        assign bus.o_pipe_y[COORD_W*gi +: COORD_W] = y_q;

        // Slot update: scroll or retire a live pipe, or take a new spawn if picked
        always_comb begin
            valid_d = valid_q;
            x_d     = x_q;
            y_d     = y_q;
            if (clear_slots) begin
                valid_d = 1'b0;
            end else if (run_stb) begin
                if (valid_q) begin
                    if (x_q <= SPEED_C) begin
                        valid_d = 1'b0;
                    end else begin
                        x_d = x_moved;
                    end
                end else if (spawn && pick_vec[gi]) begin
                    valid_d = 1'b1;
                    x_d     = SPAWN_C;
                    y_d     = gap;
                end
            end
        end

        // Slot registers
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
            end else begin
                valid_q <= valid_d;
                x_q     <= x_d;
                y_q     <= y_d;
            end
        end
    end

    assign bus.o_state       = state_q;
    assign bus.o_pipe_valid  = valid_vec;
    assign bus.o_score       = score_q;
    assign bus.o_score_pulse = pulse_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench: a 3-slot and a 1-slot scheduler driven with identical
// stimulus, checked against hand-computed positions, gaps and scores.
module tb_pipe_scheduler;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    pipe_scheduler_if #(.NPIPE(3)) bus3 ();
    pipe_scheduler_if #(.NPIPE(1)) bus1 ();

    pipe_scheduler #(.NPIPE(3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3.slave)
    );

    pipe_scheduler #(.NPIPE(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input logic stb, input logic start, input logic collide);
        bus3.i_physics_stb = stb;
        bus3.i_start       = start;
        bus3.i_collide     = collide;
        bus1.i_physics_stb = stb;
        bus1.i_start       = start;
        bus1.i_collide     = collide;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, 1'b0, 1'b0);
            tick();
            set_in(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_start();
        set_in(1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset state
        check("rst_state",  32'(bus3.o_state), 32'd0);
        check("rst_valid",  32'(bus3.o_pipe_valid), 32'd0);
        check("rst_x",      32'(bus3.o_pipe_x), 32'd0);
        check("rst_y",      32'(bus3.o_pipe_y), 32'd0);
        check("rst_score",  32'(bus3.o_score), 32'd0);
        check("rst_pulse",  32'(bus3.o_score_pulse), 32'd0);
        $display("step reset: state=%0d valid=%b", bus3.o_state, bus3.o_pipe_valid);
        rst = 1'b0;
        tick();

        // Start: RUN, first strobe spawns slot0
        pulse_start();
        check("start_state", 32'(bus3.o_state), 32'd1);
        check("start_valid", 32'(bus3.o_pipe_valid), 32'd0);
        strobes(1);
        check("s1_valid", 32'(bus3.o_pipe_valid), 32'b001);
        check("s1_x0",    32'(bus3.o_pipe_x[11:0]), 32'd680);
        check("s1_y0",    32'(bus3.o_pipe_y[11:0]), 32'd220);
        check("s1_n1_y0", 32'(bus1.o_pipe_y[11:0]), 32'd220);
        $display("strobe 1: valid=%b x0=%0d y0=%0d", bus3.o_pipe_valid, bus3.o_pipe_x[11:0], bus3.o_pipe_y[11:0]);

        // 40 strobes later slot1 spawns
        strobes(40);
        check("s41_valid", 32'(bus3.o_pipe_valid), 32'b011);
        check("s41_x0",    32'(bus3.o_pipe_x[11:0]), 32'd400);
        check("s41_x1",    32'(bus3.o_pipe_x[23:12]), 32'd680);
        check("s41_y1",    32'(bus3.o_pipe_y[23:12]), 32'd130);
        check("s41_n1_valid", 32'(bus1.o_pipe_valid), 32'd1);
        check("s41_n1_x0",    32'(bus1.o_pipe_x), 32'd400);
        $display("strobe 41: valid=%b x0=%0d x1=%0d", bus3.o_pipe_valid, bus3.o_pipe_x[11:0], bus3.o_pipe_x[23:12]);

        // Scoring around the bird
        strobes(34);
        check("s75_x0",    32'(bus3.o_pipe_x[11:0]), 32'd162);
        check("s75_score", 32'(bus3.o_score), 32'd0);
        check("s75_pulse", 32'(bus3.o_score_pulse), 32'd0);
        strobes(1);
        check("s76_x0",    32'(bus3.o_pipe_x[11:0]), 32'd155);
        check("s76_score", 32'(bus3.o_score), 32'd1);
        check("s76_pulse", 32'(bus3.o_score_pulse), 32'd1);
        check("s76_n1_score", 32'(bus1.o_score), 32'd1);
        $display("strobe 76: x0=%0d score=%0d pulse=%0d", bus3.o_pipe_x[11:0], bus3.o_score, bus3.o_score_pulse);
        tick();
        check("idle_pulse", 32'(bus3.o_score_pulse), 32'd0);
        strobes(1);
        check("s77_pulse", 32'(bus3.o_score_pulse), 32'd0);
        check("s77_score", 32'(bus3.o_score), 32'd1);

        // Third spawn; single-slot build has no room
        strobes(4);
        check("s81_valid", 32'(bus3.o_pipe_valid), 32'b111);
        check("s81_x2",    32'(bus3.o_pipe_x[35:24]), 32'd680);
        check("s81_y2",    32'(bus3.o_pipe_y[35:24]), 32'd310);
        check("s81_n1_valid", 32'(bus1.o_pipe_valid), 32'd1);
        $display("strobe 81: valid=%b x2=%0d", bus3.o_pipe_valid, bus3.o_pipe_x[35:24]);

        // Retirement at the left edge
        strobes(16);
        check("s97_x0", 32'(bus3.o_pipe_x[11:0]), 32'd8);
        strobes(1);
        check("s98_x0",    32'(bus3.o_pipe_x[11:0]), 32'd1);
        check("s98_valid", 32'(bus3.o_pipe_valid), 32'b111);
        strobes(1);
        check("s99_valid",    32'(bus3.o_pipe_valid), 32'b110);
        check("s99_n1_valid", 32'(bus1.o_pipe_valid), 32'd0);
        strobes(1);
        check("s100_n1_valid", 32'(bus1.o_pipe_valid), 32'd1);
        check("s100_n1_x",     32'(bus1.o_pipe_x), 32'd680);
        check("s100_n1_y",     32'(bus1.o_pipe_y), 32'd130);
        check("s100_valid",    32'(bus3.o_pipe_valid), 32'b110);
        check("s100_x1",       32'(bus3.o_pipe_x[23:12]), 32'd267);
        check("s100_x2",       32'(bus3.o_pipe_x[35:24]), 32'd547);
        $display("strobe 100: n1 valid=%b x=%0d y=%0d", bus1.o_pipe_valid, bus1.o_pipe_x, bus1.o_pipe_y);

        // Collision together with a strobe: HALT, nothing moves
        set_in(1'b1, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        check("halt_state", 32'(bus3.o_state), 32'd2);
        check("halt_x1",    32'(bus3.o_pipe_x[23:12]), 32'd267);
        check("halt_x2",    32'(bus3.o_pipe_x[35:24]), 32'd547);
        check("halt_valid", 32'(bus3.o_pipe_valid), 32'b110);
        check("halt_n1_x",  32'(bus1.o_pipe_x), 32'd680);
        strobes(1);
        check("halt_frozen_x1", 32'(bus3.o_pipe_x[23:12]), 32'd267);
        check("halt_score",     32'(bus3.o_score), 32'd1);
        $display("halt: state=%0d x1=%0d", bus3.o_state, bus3.o_pipe_x[23:12]);

        // HALT -> IDLE clears slots, keeps score
        pulse_start();
        check("idle_state", 32'(bus3.o_state), 32'd0);
        check("idle_valid", 32'(bus3.o_pipe_valid), 32'd0);
        check("idle_score", 32'(bus3.o_score), 32'd1);
        check("idle_n1_valid", 32'(bus1.o_pipe_valid), 32'd0);

        // New game: score cleared, gap table restarts
        pulse_start();
        check("rerun_state", 32'(bus3.o_state), 32'd1);
        check("rerun_score", 32'(bus3.o_score), 32'd0);
        strobes(1);
        check("rerun_valid", 32'(bus3.o_pipe_valid), 32'b001);
        check("rerun_x0",    32'(bus3.o_pipe_x[11:0]), 32'd680);
        check("rerun_y0",    32'(bus3.o_pipe_y[11:0]), 32'd220);
        $display("rerun: valid=%b y0=%0d", bus3.o_pipe_valid, bus3.o_pipe_y[11:0]);

        // Reset in the middle of a run
        strobes(3);
        rst = 1'b1;
        tick();
        check("mrst_state", 32'(bus3.o_state), 32'd0);
        check("mrst_valid", 32'(bus3.o_pipe_valid), 32'd0);
        check("mrst_x",     32'(bus3.o_pipe_x), 32'd0);
        check("mrst_y",     32'(bus3.o_pipe_y), 32'd0);
        check("mrst_score", 32'(bus3.o_score), 32'd0);
        check("mrst_n1_valid", 32'(bus1.o_pipe_valid), 32'd0);
        $display("mid-run reset: state=%0d valid=%b", bus3.o_state, bus3.o_pipe_valid);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
